// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage issue, hazard and HI/LO read bundle
// for the multiply/divide controller.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  HILO_Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] HILO_out;

  modport master (
    output start, HILO_Op, A, B, D_is_md,
    input  busy, stall, HILO_out
  );

  modport slave (
    input  start, HILO_Op, A, B, D_is_md,
    output busy, stall, HILO_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multicycle mult/div HI/LO unit with busy/stall.
// MDU_DIVZERO_HOLD_EN: divide by zero leaves HI/LO unchanged.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CLG  = $clog2(MAXC + 1);
  localparam int CW   = (CLG < 4) ? 4 : CLG;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi;
  logic [31:0]   lo;

  logic        go;
  logic        is_mul;
  logic        div_op;
  logic        sdiv;
  logic        div0;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quo;
  logic [31:0] rem;

  assign go = bus.start &&
              (bus.HILO_Op >= 4'd1) &&
              (bus.HILO_Op <= 4'd4);
  assign is_mul = (bus.HILO_Op <= 4'd2);

  assign div_op = (op_q == 4'd3) || (op_q == 4'd4);
  assign sdiv   = (op_q == 4'd3);
  assign div0   = div_op && (b_q == 32'd0);

  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s = {{32{a_q[31]}}, a_q} *
                  {{32{b_q[31]}}, b_q};

  assign a_mag = (sdiv && a_q[31]) ? -a_q : a_q;
  assign b_mag = (sdiv && b_q[31]) ? -b_q : b_q;
  assign q_u   = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_u   = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quo   = (sdiv && (a_q[31] ^ b_q[31])) ? -q_u : q_u;
  assign rem   = (sdiv && a_q[31]) ? -r_u : r_u;

  assign bus.busy  = (state == RUN);
  assign bus.stall = bus.D_is_md & (bus.start | bus.busy);
  assign bus.HILO_out = (bus.HILO_Op == 4'd5) ? hi :
                        (bus.HILO_Op == 4'd6) ? lo : 32'd0;

  // issue, count down, commit HI/LO; mthi/mtlo only while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            op_q  <= bus.HILO_Op;
            a_q   <= bus.A;
            b_q   <= bus.B;
            cnt   <= is_mul ? CW'(MULT_CYCLES) :
                              CW'(DIV_CYCLES);
            state <= RUN;
          end else if (bus.HILO_Op == 4'd7) begin
            hi <= bus.A;
          end else if (bus.HILO_Op == 4'd8) begin
            lo <= bus.A;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            unique case (1'b1)
              op_q == 4'd1: {hi, lo} <= prod_s;
              op_q == 4'd2: {hi, lo} <= prod_u;
`ifdef MDU_DIVZERO_HOLD_EN
              div0: {hi, lo} <= {hi, lo};
`else
              div0: {hi, lo} <= {a_q, 32'hFFFF_FFFF};
`endif
              div_op && !div0: {hi, lo} <= {rem, quo};
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl
// against a 64-bit arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ctrl_if bus();

  mdu_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.start   = 1'b0;
    bus.HILO_Op = 4'd0;
  endtask

  task automatic read_check(input string tag);
    bus.HILO_Op = 4'd5;
    #1;
    chk({tag, "_hi"}, bus.HILO_out, m_hi);
    bus.HILO_Op = 4'd6;
    #1;
    chk({tag, "_lo"}, bus.HILO_out, m_lo);
    bus.HILO_Op = 4'd0;
    #1;
    chk({tag, "_none"}, bus.HILO_out, 32'd0);
  endtask

  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
      end
      4'd2: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
      end
      default: begin
        if (b == 32'd0) begin
`ifndef MDU_DIVZERO_HOLD_EN
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
`endif
        end else if (op == 4'd3) begin
          p = 64'(sa / sb);
          m_lo = p[31:0];
          p = 64'(sa % sb);
          m_hi = p[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic dmd,
                        input bit poke);
    int n;
    n = (op <= 4'd2) ? MC : DC;
    bus.start   = 1'b1;
    bus.HILO_Op = op;
    bus.A       = a;
    bus.B       = b;
    bus.D_is_md = dmd;
    #1;
    chk("stall_issue", 32'(bus.stall), 32'(dmd));
    tick();
    for (int i = 1; i <= n; i++) begin
      bus.A = $urandom;
      bus.B = $urandom;
      if (poke && i == 2) begin
        bus.start   = 1'b1;
        bus.HILO_Op = 4'($urandom_range(1, 8));
      end else begin
        idle_in();
      end
      #1;
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("stall_run", 32'(bus.stall), 32'(dmd));
      tick();
    end
    idle_in();
    #1;
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("stall_done", 32'(bus.stall), 32'd0);
    model(op, a, b);
    read_check("res");
  endtask

  task automatic mt(input logic [3:0] op,
                    input logic [31:0] a);
    bus.start   = 1'b0;
    bus.HILO_Op = op;
    bus.A       = a;
    tick();
    if (op == 4'd7) m_hi = a;
    else m_lo = a;
    idle_in();
    #1;
    chk("mt_busy", 32'(bus.busy), 32'd0);
    read_check("mt");
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    idle_in();
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h1;
    bus.D_is_md = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    read_check("rst");

    bus.start = 1'b1;
    bus.HILO_Op = 4'd1;
    tick();
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    bus.HILO_Op = 4'd7;
    tick();
    reset = 1'b0;
    idle_in();
    read_check("rst_mthi");

    bus.start = 1'b1;
    bus.HILO_Op = 4'd0;
    tick();
    chk("bad_op_busy", 32'(bus.busy), 32'd0);
    bus.HILO_Op = 4'd5;
    tick();
    chk("bad_op5_busy", 32'(bus.busy), 32'd0);
    idle_in();

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_hi", m_hi, 32'hFFFF_FFFF);
    chk("mult_lo", m_lo, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("multu_hi", m_hi, 32'h0000_0001);
    chk("multu_lo", m_lo, 32'hFFFF_FFFE);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_lo", m_lo, 32'hFFFF_FFFD);
    chk("div_hi", m_hi, 32'hFFFF_FFFF);

    mt(4'd7, 32'h1234);
    run_op(4'd1, 32'd7, 32'd6, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.HILO_Op = 4'd1;
    bus.A = 32'd11;
    bus.B = 32'd13;
    tick();
    bus.start = 1'b0;
    bus.HILO_Op = 4'd8;
    bus.A = 32'd5;
    tick();
    bus.HILO_Op = 4'd8;
    tick();
    idle_in();
    for (int i = 0; i < MC; i++) tick();
    model(4'd1, 32'd11, 32'd13);
    read_check("mtlo_in_run");
    chk("mtlo_in_run_lo", m_lo, 32'd143);

    run_op(4'd4, 32'd9, 32'd0, 1'b0, 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
           1'b0, 1'b0);
    chk("ovf_lo", m_lo, 32'h8000_0000);
    chk("ovf_hi", m_hi, 32'd0);
    run_op(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);

    bus.start = 1'b1;
    bus.HILO_Op = 4'd3;
    bus.A = 32'd1000;
    bus.B = 32'd7;
    tick();
    idle_in();
    for (int i = 1; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < DC + 2; i++) tick();
    chk("abort_idle", 32'(bus.busy), 32'd0);
    read_check("abort");

    for (int k = 0; k < 20; k++) begin
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ?
          32'd0 : 32'($urandom);
      if ($urandom_range(0, 1) == 1)
        b = 32'($urandom_range(1, 20));
      run_op(op, a, b, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        mt(4'($urandom_range(7, 8)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage mult/multu/div/divu issue strobe.
REQ-006 HILO_Op  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 0 none.
REQ-007 A  input  32  forwarded rs operand (E stage).
REQ-008 B  input  32  forwarded rt operand (E stage).
REQ-009 D_is_md  input  1  D-stage instruction has nonzero HILO_Op.
REQ-010 busy  output  1  operation in progress.
REQ-011 stall  output  1  pipeline freeze request to the hazard unit.
REQ-012 HILO_out  output  32  mfhi/mflo read data.

Function
REQ-013 Two states: IDLE, RUN; down-counter cnt, 4 bits minimum, wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 IDLE and start=1 with HILO_Op in 1..4: latch op, A, B; cnt loaded with MULT_CYCLES or DIV_CYCLES; next state RUN.
REQ-015 start=1 with HILO_Op outside 1..4 is ignored.
REQ-016 busy=1 exactly while in RUN; start sampled at edge t gives busy=1 for cycles t+1..t+N (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 cnt decrements each RUN cycle; at the edge ending cycle t+N, HI/LO commit and state returns to IDLE.
REQ-018 New HI/LO are visible from cycle t+N+1, the first cycle with busy=0.
REQ-019 mult: {HI,LO} = signed 64-bit product A*B; multu: unsigned 64-bit product.
REQ-020 div: LO = signed quotient, HI = signed remainder, both truncated toward zero, remainder sign equals dividend sign; divu: unsigned.
REQ-021 div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-022 Results derive from operands latched at start; A/B changes during RUN have no effect.
REQ-023 mthi (7) / mtlo (8) in IDLE: HI/LO <= A at the next edge.
REQ-024 mthi/mtlo during RUN are ignored.
REQ-025 start during RUN is ignored; no queueing.
REQ-026 HILO_out is combinational: HI when HILO_Op=5, LO when HILO_Op=6, else 0; it shows the committed register value.
REQ-027 stall = D_is_md & (start | busy), combinational.
REQ-028 stall deasserts in cycle t+N+1.

Reset
REQ-029 reset=1 at an edge: state IDLE, cnt=0, HI=0, LO=0, latched op/operands=0.
REQ-030 During reset, busy=0 and stall=0 follow from IDLE state.
REQ-031 reset overrides start or mthi/mtlo in the same cycle.
REQ-032 reset mid-RUN aborts the operation with no HI/LO commit.

Configuration
REQ-033 Macro MDU_DIVZERO_HOLD_EN defined: div/divu with latched B=0 still runs DIV_CYCLES, then leaves HI and LO unchanged.
REQ-034 Macro MDU_DIVZERO_HOLD_EN undefined: divide by zero commits HI=latched A, LO=0xFFFFFFFF, for both div and divu.

Verification
REQ-035 reset, then mult A=0xFFFFFFFE B=3 -> busy high 5 cycles; cycle 6: mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA.
REQ-036 multu A=0xFFFFFFFF B=2 -> after 5 busy cycles: HI=0x00000001, LO=0xFFFFFFFE.
REQ-037 div A=-7 B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; D_is_md=1 throughout -> stall high in issue cycle plus 10 busy cycles, low in cycle 11.
REQ-038 mthi A=0x1234 in IDLE -> next cycle mfhi=0x1234; start mult, mtlo A=5 at RUN cycle 2 -> LO holds the product, not 5.
REQ-039 divu A=9 B=0 -> with MDU_DIVZERO_HOLD_EN, HI/LO unchanged; without it, HI=9, LO=0xFFFFFFFF.
REQ-040 div issued, reset asserted at RUN cycle 4 -> next cycle busy=0, HI=LO=0, no later commit.
